// File: rtl/bsg_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bsg_fifo_ctrl_pkg
//   Shared types and helpers for the 1R1W FIFO controller.
//   - fifo_state_e : occupancy state of the controller (EMPTY/PARTIAL/FULL)
//   - safe_clog2   : clog2 that never returns 0, so a depth of 1 or 2 still
//                    yields a 1-bit address
// -----------------------------------------------------------------------------
package bsg_fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } fifo_state_e;

   function automatic int safe_clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_fifo_ctrl_ptr.sv
// -----------------------------------------------------------------------------
// bsg_fifo_ctrl_ptr
//   Wrapping pointer for a FIFO of arbitrary (non power-of-two) depth. Counts
//   0..els_p-1 and wraps back to 0 by explicit compare.
// Ports:
//   clk_i       in   clock, state on posedge
//   reset_n_i   in   asynchronous active-low reset, pointer -> 0
//   incr_i      in   advance the pointer on this clock edge
//   ptr_o       out  current pointer value (flop output)
//   ptr_next_o  out  value the pointer takes on the next edge
// -----------------------------------------------------------------------------
module bsg_fifo_ctrl_ptr
   import bsg_fifo_ctrl_pkg::*;
#(
   parameter int els_p        = 2,
   parameter int ptr_width_lp = safe_clog2(els_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    incr_i,
   output logic [ptr_width_lp-1:0] ptr_o,
   output logic [ptr_width_lp-1:0] ptr_next_o
);

   localparam logic [ptr_width_lp-1:0] last_lp = ptr_width_lp'(els_p - 1);

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      ptr_next_o = ptr_o;
      if (incr_i) begin
         ptr_next_o = (ptr_o == last_lp) ? '0 : ptr_o + ptr_width_lp'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ptr_o <= '0;
      end else begin
         ptr_o <= ptr_next_o;
      end
   end

endmodule

// File: rtl/bsg_fifo_1r1w_ctrl.sv
// -----------------------------------------------------------------------------
// bsg_fifo_1r1w_ctrl
//   Ready/valid FIFO controller in front of a 1R1W asynchronous-read memory.
//   Generates all memory addresses/enables; read and write addresses only
//   coincide when EMPTY (no read) or FULL (no write), so the memory needs no
//   same-address read/write support and no bypass path exists.
// Ports:
//   clk_i, reset_n_i            clock / async active-low reset
//   v_i, data_i, ready_o        input stream (ready_o is a flop output)
//   v_o, data_o, yumi_i         output stream (data_o = mem_r_data_i)
//   count_o                     occupancy 0..els_p (flop output)
//   mem_w_v_o/addr_o/data_o     memory write port (tail pointer)
//   mem_r_v_o/addr_o, mem_r_data_i  memory read port (head pointer)
// Configuration:
//   BSG_FIFO_1R1W_CTRL_ASSERT_EN  enables simulation protocol assertions.
// Parameters width_p and els_p must always be set by the integrator.
// -----------------------------------------------------------------------------
module bsg_fifo_1r1w_ctrl
   import bsg_fifo_ctrl_pkg::*;
#(
   parameter int width_p        = 1,
   parameter int els_p          = 2,
   parameter int addr_width_lp  = safe_clog2(els_p),
   parameter int count_width_lp = $clog2(els_p + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,

   input  logic                      v_i,
   input  logic [width_p-1:0]        data_i,
   output logic                      ready_o,

   output logic                      v_o,
   output logic [width_p-1:0]        data_o,
   input  logic                      yumi_i,

   output logic [count_width_lp-1:0] count_o,

   output logic                      mem_w_v_o,
   output logic [addr_width_lp-1:0]  mem_w_addr_o,
   output logic [width_p-1:0]        mem_w_data_o,
   output logic                      mem_r_v_o,
   output logic [addr_width_lp-1:0]  mem_r_addr_o,
   input  logic [width_p-1:0]        mem_r_data_i
);

   fifo_state_e                state_r, state_n;
   logic                       v_r, ready_r;
   logic [count_width_lp-1:0]  count_r;
   logic                       enq, deq;
   logic [addr_width_lp-1:0]   head, head_next, tail, tail_next;

   // NOTE: the memory array itself is never reset; head/tail/state alone decide
   // which entries are valid, so a reset discards contents instantly.
   bsg_fifo_ctrl_ptr #(.els_p(els_p), .ptr_width_lp(addr_width_lp)) u_head (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .incr_i     (deq),
      .ptr_o      (head),
      .ptr_next_o (head_next)
   );

   bsg_fifo_ctrl_ptr #(.els_p(els_p), .ptr_width_lp(addr_width_lp)) u_tail (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .incr_i     (enq),
      .ptr_o      (tail),
      .ptr_next_o (tail_next)
   );

   // State register. v_o/ready_o are registered from the next state so they
   // are pure flop outputs rather than a decode of state_r.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= EMPTY;
         v_r     <= 1'b0;
         ready_r <= 1'b1;
         count_r <= '0;
      end else begin
         state_r <= state_n;
         v_r     <= (state_n != EMPTY);
         ready_r <= (state_n != FULL);
         case ({enq, deq})
            2'b10:   count_r <= count_r + count_width_lp'(1);
            2'b01:   count_r <= count_r - count_width_lp'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Next-state logic. Enq and deq together in PARTIAL keep the occupancy,
   // so only single-sided transfers can reach FULL or EMPTY.
   always_comb begin
      state_n = state_r;
      case (state_r)
         EMPTY:   if (enq) state_n = PARTIAL;
         PARTIAL: begin
            if (enq && !deq && (tail_next == head))      state_n = FULL;
            else if (deq && !enq && (head_next == tail)) state_n = EMPTY;
         end
         FULL:    if (deq) state_n = PARTIAL;
         default: state_n = EMPTY;
      endcase
   end

   // Output logic. deq is gated by v_r so an illegal yumi while empty cannot
   // move the head pointer.
   always_comb begin
      enq          = v_i & ready_r;
      deq          = yumi_i & v_r;
      ready_o      = ready_r;
      v_o          = v_r;
      count_o      = count_r;
      data_o       = mem_r_data_i;
      mem_w_v_o    = enq;
      mem_w_addr_o = tail;
      mem_w_data_o = data_i;
      mem_r_v_o    = v_r;
      mem_r_addr_o = head;
   end

`ifdef BSG_FIFO_1R1W_CTRL_ASSERT_EN
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(yumi_i && !v_r))
            else $error("bsg_fifo_1r1w_ctrl: yumi_i asserted while v_o=0");
         assert (count_r <= count_width_lp'(els_p))
            else $error("bsg_fifo_1r1w_ctrl: count_o exceeds els_p");
         assert (!(mem_w_v_o && mem_r_v_o && (mem_w_addr_o == mem_r_addr_o)))
            else $error("bsg_fifo_1r1w_ctrl: same-address read and write");
      end
   end
`else
   // Assertions disabled: no checking logic is elaborated.
`endif

endmodule

// File: tb/tb_bsg_fifo_1r1w_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bsg_fifo_1r1w_ctrl
//   Self-checking bench for bsg_fifo_1r1w_ctrl. Two instances (els_p=4 and
//   els_p=3, width_p=8) each drive a small async-read memory model. A
//   reference model of occupancy/pointers plus a data scoreboard produces all
//   expected values.
// -----------------------------------------------------------------------------
module tb_bsg_fifo_1r1w_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance 0 : els_p = 4 ----------------
   logic       v4 = 1'b0, y4 = 1'b0;
   logic [7:0] d4 = '0;
   logic       ready4, vo4, mwv4, mrv4;
   logic [7:0] do4, mwd4, mrd4;
   logic [2:0] cnt4;
   logic [1:0] mwa4, mra4;
   logic [7:0] mem4 [4];

   bsg_fifo_1r1w_ctrl #(.width_p(8), .els_p(4)) u_dut4 (
      .clk_i        (clk),
      .reset_n_i    (rst_n),
      .v_i          (v4),
      .data_i       (d4),
      .ready_o      (ready4),
      .v_o          (vo4),
      .data_o       (do4),
      .yumi_i       (y4),
      .count_o      (cnt4),
      .mem_w_v_o    (mwv4),
      .mem_w_addr_o (mwa4),
      .mem_w_data_o (mwd4),
      .mem_r_v_o    (mrv4),
      .mem_r_addr_o (mra4),
      .mem_r_data_i (mrd4)
   );

   always_ff @(posedge clk) if (mwv4) mem4[mwa4] <= mwd4;
   assign mrd4 = mem4[mra4];

   // ---------------- instance 1 : els_p = 3 ----------------
   logic       v3 = 1'b0, y3 = 1'b0;
   logic [7:0] d3 = '0;
   logic       ready3, vo3, mwv3, mrv3;
   logic [7:0] do3, mwd3, mrd3;
   logic [1:0] cnt3;
   logic [1:0] mwa3, mra3;
   logic [7:0] mem3 [4];

   bsg_fifo_1r1w_ctrl #(.width_p(8), .els_p(3)) u_dut3 (
      .clk_i        (clk),
      .reset_n_i    (rst_n),
      .v_i          (v3),
      .data_i       (d3),
      .ready_o      (ready3),
      .v_o          (vo3),
      .data_o       (do3),
      .yumi_i       (y3),
      .count_o      (cnt3),
      .mem_w_v_o    (mwv3),
      .mem_w_addr_o (mwa3),
      .mem_w_data_o (mwd3),
      .mem_r_v_o    (mrv3),
      .mem_r_addr_o (mra3),
      .mem_r_data_i (mrd3)
   );

   always_ff @(posedge clk) if (mwv3) mem3[mwa3] <= mwd3;
   assign mrd3 = mem3[mra3];

   // ---------------- reference model / scoreboard ----------------
   int         cnt_m  [2] = '{0, 0};
   int         head_m [2] = '{0, 0};
   int         tail_m [2] = '{0, 0};
   logic [7:0] q4 [$];
   logic [7:0] q3 [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int els_of(input int u);
      return (u == 0) ? 4 : 3;
   endfunction

   // Compare flop outputs and head data of instance u against the model.
   task automatic check_state(input int u);
      int els;
      els = els_of(u);
      if (u == 0) begin
         check("u0 count_o",   32'(cnt4),  32'(cnt_m[0]));
         check("u0 v_o",       32'(vo4),   32'(cnt_m[0] != 0));
         check("u0 ready_o",   32'(ready4), 32'(cnt_m[0] != els));
         check("u0 mem_r_v_o", 32'(mrv4),  32'(cnt_m[0] != 0));
         if (cnt_m[0] != 0 && q4.size() != 0) check("u0 head data", 32'(do4), 32'(q4[0]));
      end else begin
         check("u1 count_o",   32'(cnt3),  32'(cnt_m[1]));
         check("u1 v_o",       32'(vo3),   32'(cnt_m[1] != 0));
         check("u1 ready_o",   32'(ready3), 32'(cnt_m[1] != els));
         check("u1 mem_r_v_o", 32'(mrv3),  32'(cnt_m[1] != 0));
         if (cnt_m[1] != 0 && q3.size() != 0) check("u1 head data", 32'(do3), 32'(q3[0]));
      end
   endtask

   // One clock cycle on instance u. Called at posedge+1; returns at posedge+1.
   task automatic step(input int u, input logic v, input logic [7:0] d, input logic y);
      int         els;
      logic       enq_m, deq_m;
      logic [7:0] popped;
      els   = els_of(u);
      if (u == 0) begin v4 = v; d4 = d; y4 = y; end
      else        begin v3 = v; d3 = d; y3 = y; end
      enq_m = v && (cnt_m[u] != els);
      deq_m = y && (cnt_m[u] != 0);
      @(negedge clk);
      check_state(u);
      if (u == 0) begin
         check("u0 mem_w_v_o", 32'(mwv4), 32'(enq_m));
         if (enq_m)       check("u0 mem_w_addr_o", 32'(mwa4), 32'(tail_m[0]));
         if (cnt_m[0] != 0) check("u0 mem_r_addr_o", 32'(mra4), 32'(head_m[0]));
         if (deq_m) begin
            checks++;
            assert (q4.size() != 0) else begin
               errors++;
               $error("FAIL u0 scoreboard: observed dequeue expected empty queue");
            end
            if (q4.size() != 0) begin
               popped = q4.pop_front();
               check("u0 deq data", 32'(do4), 32'(popped));
            end
         end
         if (enq_m) q4.push_back(d);
      end else begin
         check("u1 mem_w_v_o", 32'(mwv3), 32'(enq_m));
         if (enq_m)       check("u1 mem_w_addr_o", 32'(mwa3), 32'(tail_m[1]));
         if (cnt_m[1] != 0) check("u1 mem_r_addr_o", 32'(mra3), 32'(head_m[1]));
         if (deq_m) begin
            checks++;
            assert (q3.size() != 0) else begin
               errors++;
               $error("FAIL u1 scoreboard: observed dequeue expected empty queue");
            end
            if (q3.size() != 0) begin
               popped = q3.pop_front();
               check("u1 deq data", 32'(do3), 32'(popped));
            end
         end
         if (enq_m) q3.push_back(d);
      end
      if (enq_m) tail_m[u] = (tail_m[u] + 1 == els) ? 0 : tail_m[u] + 1;
      if (deq_m) head_m[u] = (head_m[u] + 1 == els) ? 0 : head_m[u] + 1;
      cnt_m[u] = cnt_m[u] + int'(enq_m) - int'(deq_m);
      @(posedge clk);
      #1;
      if (u == 0) begin v4 = 1'b0; y4 = 1'b0; end
      else        begin v3 = 1'b0; y3 = 1'b0; end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         cnt_m[i]  = 0;
         head_m[i] = 0;
         tail_m[i] = 0;
      end
      q4.delete();
      q3.delete();
   endtask

   initial begin
      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check_state(0);
      check_state(1);
      check("reset u0 mem_w_v_o", 32'(mwv4), 32'd0);
      check("reset u1 mem_w_v_o", 32'(mwv3), 32'd0);
      rst_n = 1'b1;

      // ---- first enqueue: no bypass, 1-cycle latency ----
      step(0, 1'b1, 8'h11, 1'b0);
      check_state(0);
      check("first word data_o", 32'(do4), 32'h11);
      check("first word count_o", 32'(cnt4), 32'd1);
      step(0, 1'b0, 8'h00, 1'b1);

      // ---- fill to FULL, then v_i held while FULL ----
      for (int i = 0; i < 4; i++) step(0, 1'b1, 8'(8'hA0 + i), 1'b0);
      check_state(0);
      check("full ready_o", 32'(ready4), 32'd0);
      check("full count_o", 32'(cnt4), 32'd4);
      step(0, 1'b1, 8'hFF, 1'b0);

      // ---- FULL with v_i and yumi_i together: only the dequeue happens ----
      step(0, 1'b1, 8'hFF, 1'b1);
      check_state(0);
      check("after full deq data_o", 32'(do4), 32'hA1);
      check("after full deq count_o", 32'(cnt4), 32'd3);
      check("after full deq ready_o", 32'(ready4), 32'd1);
      repeat (3) step(0, 1'b0, 8'h00, 1'b1);
      check_state(0);

      // ---- els_p=3 streaming with pointer wrap ----
      step(1, 1'b1, 8'h00, 1'b0);
      for (int k = 1; k < 10; k++) begin
         step(1, 1'b1, 8'(k), 1'b1);
         check("stream count_o", 32'(cnt3), 32'd1);
      end
      step(1, 1'b0, 8'h00, 1'b1);
      check_state(1);

      // ---- asynchronous reset mid-stream ----
      step(0, 1'b1, 8'h21, 1'b0);
      step(0, 1'b1, 8'h22, 1'b0);
      check("pre-reset count_o", 32'(cnt4), 32'd2);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("reset mid v_o", 32'(vo4), 32'd0);
      check("reset mid count_o", 32'(cnt4), 32'd0);
      check("reset mid ready_o", 32'(ready4), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 1'b1, 8'h5A, 1'b0);
      check("post-reset data_o", 32'(do4), 32'h5A);
      step(0, 1'b0, 8'h00, 1'b1);
      check_state(0);

`ifndef BSG_FIFO_1R1W_CTRL_ASSERT_EN
      // ---- yumi_i while EMPTY is ignored ----
      step(0, 1'b0, 8'h00, 1'b1);
      check_state(0);
      check("empty yumi count_o", 32'(cnt4), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
